ahb_slave_mem: RTL and testbench
================================

// Module: ahb_slave_mem
// PURPOSE
//  AHB-Lite responder: the slave end of the AHB interface the bridge's master drives. Decodes
//  selected transfers into a local byte-addressable memory with configurable wait states and
//  size/alignment checking. It is the target for bridge bring-up and the AHB-side reference
//  model in system tests.
// PARAMETERS
//  ADDR_BASE    32'h8000_0000  byte address of memory word 0
//  MEM_DEPTH    64             number of 32-bit words (power of 2, 4..4096)
//  WAIT_STATES  0              extra low-hreadyout cycles per OKAY data phase (0..15)
// PORTS
//  hclk       in   1   clock, all state on rising edge
//  hreset     in   1   asynchronous, active-high reset
//  hsel       in   1   slave select, sampled with the address phase
//  haddr      in   32  transfer byte address
//  htrans     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hwrite     in   1   1 = write, 0 = read
//  hsize      in   3   0 byte, 1 halfword, 2 word; >2 is illegal
//  hburst     in   3   burst type; informational only, not checked
//  hwdata     in   32  write data, valid in the write data phase
//  hreadyin   in   1   bus ready; an address phase is accepted only when high
//  hreadyout  out  1   this slave's ready; low stalls the data phase
//  hresp      out  2   00 OKAY, 01 ERROR
//  hrdata     out  32  read data, valid in the final cycle of a read data phase
// BEHAVIOUR
//  Reset: hreadyout=1, hresp=00, hrdata=0, FSM=IDLE. The pending transfer is dropped. Memory is not reset.
//  Accept: hsel & hreadyin & htrans[1] -> register haddr, hwrite, hsize; enter the data phase next cycle.
//   IDLE/BUSY or !hsel -> zero-wait OKAY, no memory access. BUSY never ends a burst.
//  Legal check: offset = haddr-ADDR_BASE < MEM_DEPTH*4; hsize<=2; aligned (half: a[0]=0, word: a[1:0]=0).
//  FSM: IDLE -> DATA on accept. DATA holds hreadyout=0 for WAIT_STATES cycles (down-counter),
//   then drives hreadyout=1 and hresp=00, and completes.
//   Completion -> DATA again if a new accept occurs in the same cycle, else IDLE.
//   Illegal transfer (only with the macro) -> ERR1 (hreadyout=0, hresp=01) -> ERR2 (hreadyout=1, hresp=01).
//   Wait states are skipped on error. An accept during ERR2 is honoured normally.
//  Write: commits at the edge ending the final DATA cycle. Little-endian byte enables come from
//   size and a[1:0]: byte -> 1<<a[1:0]; half -> 0011 or 1100; word -> 1111. hwdata lanes map as-is.
//  Read: hrdata = mem[offset[..:2]] (full word, all lanes) in the final DATA cycle, else 0.
//   Decode is combinational from registered state.
//  Write then read of the same word back to back: the read sees the new data, with no forwarding
//   logic needed, because the write commits before the read's data phase.
//  Reset asserted mid-data-phase: a pending write is not committed. Outputs return to reset values at once.
//  Offset wraps nowhere: an address beyond the top of memory is illegal, never aliased.
// CONFIGURATION
//  AHB_SLV_ERR_EN defined: illegal transfers get the two-cycle ERROR response. No memory access.
//  Not defined: illegal transfers complete OKAY after the normal wait states.
//   An illegal write is discarded; an illegal read returns hrdata=0.
// STRUCTURE
//  ahb_pkg (shared with the bridge): HTRANS_*, HRESP_OKAY/ERROR, HSIZE_* constants,
//   and a typedef for the registered address-phase record {addr, write, size}.
//  Sub-module ahb_slv_mem_array: MEM_DEPTH x 32 array with a 4-bit byte-enable write
//   and a combinational read port.
//  Top level: address-phase register, legality decode, FSM, wait counter.
// TESTING (defaults unless stated)
//  1 Byte write 8'h80 to 0x8000_0001, then word read of 0x8000_0000
//    -> hrdata=32'h0000_8000, hresp=00, zero waits.
//  2 INCR4 word writes to 0x8000_0010..1C (SEQ beats, one BUSY mid-burst), then INCR4 read
//    -> data returned in order; the BUSY cycle is OKAY with no access.
//  3 WAIT_STATES=2, single read -> hreadyout low exactly 2 cycles, then high with valid hrdata.
//    Back-to-back NONSEQ is accepted on the completing cycle.
//  4 Read 0x8000_0100 (MEM_DEPTH=64) with the macro -> cycle1 {hreadyout,hresp}={0,01},
//    cycle2 {1,01}. Without the macro -> OKAY, hrdata=0.
//  5 Halfword write to 0x8000_0003 with the macro -> ERROR, memory unchanged (a read-back confirms).
//  6 WAIT_STATES=3, write pending; pulse hreset in the 2nd wait cycle
//    -> hreadyout=1 and hresp=00 immediately, and the target word keeps its old value.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/response/size encodings, the registered
// address-phase record, the slave FSM state type and decode helpers.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Address-phase information captured when a transfer is accepted.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
    } ahb_aphase_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_t;

    // Little-endian byte lanes touched by a transfer of the given size/alignment.
    function automatic logic [3:0] ahb_byte_en(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << a;
            HSIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

    // A transfer is legal when it lies inside the window and is naturally aligned.
    // The subtraction wraps, so addresses below the base land far out of range.
    function automatic logic ahb_legal(input logic [31:0] addr, input logic [31:0] base,
                                       input logic [31:0] bytes, input logic [2:0] size);
        logic [31:0] off;
        logic        aligned;
        off = addr - base;
        case (size)
            HSIZE_BYTE: aligned = 1'b1;
            HSIZE_HALF: aligned = ~addr[0];
            HSIZE_WORD: aligned = (addr[1:0] == 2'b00);
            default:    aligned = 1'b0;
        endcase
        return (off < bytes) && aligned;
    endfunction

endpackage

// File: rtl/ahb_slv_mem_array.sv
// Word-organised memory with per-byte write enables and a combinational read port.
// Contents are deliberately not reset.
module ahb_slv_mem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane write on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder: address-phase register, legality decode, data-phase
// FSM with a wait-state down-counter, and a byte-enabled memory.
// Optional feature macro: AHB_SLV_ERR_EN -- when defined, illegal transfers get the
// two-cycle ERROR response; otherwise they complete OKAY with no memory effect.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          MEM_DEPTH   = 64,
    parameter int          WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    input  logic        hreadyin,
    output logic        hreadyout,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    localparam int          AW        = $clog2(MEM_DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);
    localparam logic [3:0]  WS_LOAD   = 4'(WAIT_STATES);

    slv_state_t  state_q, state_d;
    ahb_aphase_t aph_q, aph_d;
    logic        legal_q, legal_d;
    logic [3:0]  wcnt_q, wcnt_d;

    logic          accept_s;
    logic          legal_in_s;
    logic          complete_s;
    logic          mem_we_s;
    logic [3:0]    mem_be_s;
    logic [AW-1:0] mem_idx_s;
    logic [31:0]   mem_rdata_s;
    logic          hburst_unused_s;

    // Burst type and the SEQ/NONSEQ distinction do not affect this responder.
    assign hburst_unused_s = ^{hburst, htrans[0]};

    assign accept_s   = hsel & hreadyin & htrans[1];
    assign legal_in_s = ahb_legal(haddr, ADDR_BASE, MEM_BYTES, hsize);
    assign mem_be_s   = ahb_byte_en(aph_q.size, aph_q.addr[1:0]);
    assign mem_idx_s  = AW'((aph_q.addr - ADDR_BASE) >> 2);

    // State, address-phase record and wait counter; async reset drops any pending transfer.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= ST_IDLE;
            aph_q   <= '0;
            legal_q <= 1'b0;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            aph_q   <= aph_d;
            legal_q <= legal_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state, handshake outputs and write strobe, all decoded from registered state.
    always_comb begin
        state_d    = state_q;
        aph_d      = aph_q;
        legal_d    = legal_q;
        wcnt_d     = wcnt_q;
        hreadyout  = 1'b1;
        hresp      = HRESP_OKAY;
        mem_we_s   = 1'b0;
        complete_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                complete_s = 1'b1;
            end
            ST_DATA: begin
                if (wcnt_q != 4'd0) begin
                    hreadyout = 1'b0;
                    wcnt_d    = wcnt_q - 4'd1;
                end else begin
                    complete_s = 1'b1;
                    mem_we_s   = aph_q.write & legal_q;
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                hresp      = HRESP_ERROR;
                complete_s = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A completing cycle doubles as the next address phase.
        if (complete_s) begin
            if (accept_s) begin
                aph_d   = '{addr: haddr, write: hwrite, size: hsize};
                legal_d = legal_in_s;
                wcnt_d  = WS_LOAD;
`ifdef AHB_SLV_ERR_EN
                state_d = legal_in_s ? ST_DATA : ST_ERR1;
`else
                state_d = ST_DATA;
`endif
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            aph_d = aph_d;
        end
    end

    // Read data is driven only in the final cycle of a legal read data phase.
    always_comb begin
        if ((state_q == ST_DATA) && (wcnt_q == 4'd0) && !aph_q.write && legal_q) begin
            hrdata = mem_rdata_s;
        end else begin
            hrdata = 32'd0;
        end
    end

    ahb_slv_mem_array #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (hclk),
        .we    (mem_we_s),
        .be    (mem_be_s),
        .addr  (mem_idx_s),
        .wdata (hwdata),
        .rdata (mem_rdata_s)
    );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: three instances (0, 2 and 3 wait states) share one
// bus; sel picks which one is addressed and whose outputs are observed.
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    localparam logic [31:0] A  = 32'h8000_0000;
    localparam logic [31:0] D0 = 32'hA0A0_0001;
    localparam logic [31:0] D1 = 32'hB1B1_0002;
    localparam logic [31:0] D2 = 32'hC2C2_0003;
    localparam logic [31:0] D3 = 32'hD3D3_0004;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel_bus;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    int          sel;

    logic        ro0, ro2, ro3;
    logic [1:0]  rs0, rs2, rs3;
    logic [31:0] rd0, rd2, rd3;
    logic        rdy;
    logic [1:0]  rsp;
    logic [31:0] rdat;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    ahb_slave_mem #(.WAIT_STATES(0)) u_ws0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_bus && (sel == 0)), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hreadyin(ro0), .hreadyout(ro0), .hresp(rs0), .hrdata(rd0));

    ahb_slave_mem #(.WAIT_STATES(2)) u_ws2 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_bus && (sel == 2)), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hreadyin(ro2), .hreadyout(ro2), .hresp(rs2), .hrdata(rd2));

    ahb_slave_mem #(.WAIT_STATES(3)) u_ws3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_bus && (sel == 3)), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hreadyin(ro3), .hreadyout(ro3), .hresp(rs3), .hrdata(rd3));

    // Observe the currently addressed instance.
    always_comb begin
        case (sel)
            2:       begin rdy = ro2; rsp = rs2; rdat = rd2; end
            3:       begin rdy = ro3; rsp = rs3; rdat = rd3; end
            default: begin rdy = ro0; rsp = rs0; rdat = rd0; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic exp_rdy, input logic [1:0] exp_resp);
        chk(tag, {29'd0, rdy, rsp}, {29'd0, exp_rdy, exp_resp});
    endtask

    task automatic tick;
        @(posedge hclk);
        #1;
    endtask

    task automatic bus(input logic [1:0] tr, input logic w, input logic [2:0] sz, input logic [31:0] a);
        hsel_bus = 1'b1;
        htrans   = tr;
        hwrite   = w;
        hsize    = sz;
        haddr    = a;
    endtask

    task automatic idle;
        bus(HTRANS_IDLE, 1'b0, HSIZE_WORD, A);
    endtask

    initial begin
        hreset = 1'b1;
        hwdata = 32'd0;
        hburst = 3'd0;
        sel    = 0;
        idle();
        repeat (2) @(posedge hclk);
        #1;
        chk_st("reset_status", 1'b1, HRESP_OKAY);
        chk("reset_rdata", rdat, 32'd0);
        @(negedge hclk);
        hreset = 1'b0;
        tick();

        // Test 1: clear word 0, byte write 0x80 to byte 1, word read back.
        bus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, A);
        tick();
        hwdata = 32'd0;
        bus(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, A + 32'h1);
        tick();
        hwdata = 32'h0000_8000;
        bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, A);
        chk_st("t1_write_status", 1'b1, HRESP_OKAY);
        tick();
        idle();
        chk("t1_read_data", rdat, 32'h0000_8000);
        chk_st("t1_read_status", 1'b1, HRESP_OKAY);
        tick();
        chk("t1_idle_rdata", rdat, 32'd0);

        // Test 2: INCR4 write with a BUSY mid-burst, then INCR4 read.
        hburst = 3'b011;
        bus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, A + 32'h10);
        tick();
        hwdata = D0;
        bus(HTRANS_SEQ, 1'b1, HSIZE_WORD, A + 32'h14);
        tick();
        hwdata = D1;
        bus(HTRANS_BUSY, 1'b1, HSIZE_WORD, A + 32'h18);
        tick();
        hwdata = 32'hDEAD_DEAD;
        bus(HTRANS_SEQ, 1'b1, HSIZE_WORD, A + 32'h18);
        chk_st("t2_busy_status", 1'b1, HRESP_OKAY);
        chk("t2_busy_rdata", rdat, 32'd0);
        tick();
        hwdata = D2;
        bus(HTRANS_SEQ, 1'b1, HSIZE_WORD, A + 32'h1C);
        tick();
        hwdata = D3;
        bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, A + 32'h10);
        tick();
        bus(HTRANS_SEQ, 1'b0, HSIZE_WORD, A + 32'h14);
        chk("t2_read_beat0", rdat, D0);
        tick();
        bus(HTRANS_SEQ, 1'b0, HSIZE_WORD, A + 32'h18);
        chk("t2_read_beat1", rdat, D1);
        tick();
        bus(HTRANS_SEQ, 1'b0, HSIZE_WORD, A + 32'h1C);
        chk("t2_read_beat2", rdat, D2);
        tick();
        idle();
        chk("t2_read_beat3", rdat, D3);
        tick();
        hburst = 3'd0;

        // Upper halfword write into word 0x10, then read back.
        bus(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, A + 32'h12);
        tick();
        hwdata = 32'hBEEF_0000;
        bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, A + 32'h10);
        tick();
        idle();
        chk("half_write_readback", rdat, 32'hBEEF_0001);
        tick();

        // Topmost word is legal.
        bus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, A + 32'hFC);
        tick();
        hwdata = 32'h5A5A_A5A5;
        bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, A + 32'hFC);
        tick();
        idle();
        chk("top_word_readback", rdat, 32'h5A5A_A5A5);
        chk_st("top_word_status", 1'b1, HRESP_OKAY);
        tick();

        // Test 4: read just past the top of memory.
        bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, A + 32'h100);
        tick();
        idle();
`ifdef AHB_SLV_ERR_EN
        chk_st("t4_err_cycle1", 1'b0, HRESP_ERROR);
        tick();
        chk_st("t4_err_cycle2", 1'b1, HRESP_ERROR);
        tick();
        chk_st("t4_after_err", 1'b1, HRESP_OKAY);
`else
        chk_st("t4_okay_status", 1'b1, HRESP_OKAY);
        chk("t4_okay_rdata", rdat, 32'd0);
        tick();
`endif

        // Test 5: misaligned halfword write must not touch word 0.
        bus(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, A + 32'h3);
        tick();
        hwdata = 32'hFFFF_FFFF;
`ifdef AHB_SLV_ERR_EN
        idle();
        chk_st("t5_err_cycle1", 1'b0, HRESP_ERROR);
        tick();
        bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, A);
        chk_st("t5_err_cycle2", 1'b1, HRESP_ERROR);
        tick();
`else
        bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, A);
        chk_st("t5_okay_status", 1'b1, HRESP_OKAY);
        tick();
`endif
        idle();
        chk("t5_word_unchanged", rdat, 32'h0000_8000);
        chk_st("t5_readback_status", 1'b1, HRESP_OKAY);
        tick();

        // Test 3: two wait states, write then back-to-back read.
        sel = 2;
        bus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, A + 32'h20);
        tick();
        hwdata = 32'hCAFE_F00D;
        bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, A + 32'h20);
        chk("t3_write_wait1", {31'd0, rdy}, 32'd0);
        tick();
        chk("t3_write_wait2", {31'd0, rdy}, 32'd0);
        tick();
        chk_st("t3_write_done", 1'b1, HRESP_OKAY);
        tick();
        idle();
        chk("t3_read_wait1", {31'd0, rdy}, 32'd0);
        chk("t3_read_wait1_rdata", rdat, 32'd0);
        tick();
        chk("t3_read_wait2", {31'd0, rdy}, 32'd0);
        tick();
        chk_st("t3_read_done", 1'b1, HRESP_OKAY);
        chk("t3_read_data", rdat, 32'hCAFE_F00D);
        tick();
        chk("t3_after_rdy", {31'd0, rdy}, 32'd1);
        chk("t3_after_rdata", rdat, 32'd0);

        // Test 6: three wait states, reset during the second wait of a write.
        sel = 3;
        bus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, A + 32'h30);
        tick();
        hwdata = 32'h1111_1111;
        idle();
        repeat (3) tick();
        chk_st("t6_first_write_done", 1'b1, HRESP_OKAY);
        tick();
        bus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, A + 32'h30);
        tick();
        hwdata = 32'h2222_2222;
        idle();
        chk("t6_wait1", {31'd0, rdy}, 32'd0);
        tick();
        chk("t6_wait2", {31'd0, rdy}, 32'd0);
        hreset = 1'b1;
        #1;
        chk_st("t6_reset_immediate", 1'b1, HRESP_OKAY);
        tick();
        hreset = 1'b0;
        tick();
        bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, A + 32'h30);
        tick();
        idle();
        repeat (3) tick();
        chk_st("t6_read_status", 1'b1, HRESP_OKAY);
        chk("t6_word_kept", rdat, 32'h1111_1111);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
